// File: rtl/serial_tx_arbiter_if.sv
// Requester-side handshake bundle and serial line outputs of serial_tx_arbiter.
// The arbiter connects through the slave modport; requesters and benches use master.
interface serial_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   // Handshake: a byte moves from requester i on a rising clk edge where
   // req_valid[i] & req_ready[i]. A requester that is valid without ready must
   // hold req_data/req_last stable; dropping valid without a transfer is legal.
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_last;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         tx_data;
   logic                         busy;
   logic [IDW-1:0]               grant_id;
   logic [1:0]                   state_dbg;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ready, tx_data, busy, grant_id, state_dbg
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ready, tx_data, busy, grant_id, state_dbg
   );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter with message locking in front of an async serial framer.
// Each accepted byte is sent as start bit, DATA_BITS LSB first, STOP_BITS stop bits.
module serial_tx_arbiter #(
   parameter int CLOCK_HZ    = 27000000,
   parameter int BIT_RATE_HZ = 115200,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int NUM_REQ     = 4
) (
   input logic clk,
   input logic reset,
   serial_tx_arbiter_if.slave bus
);
   localparam int DIV = CLOCK_HZ / BIT_RATE_HZ;
   localparam int IDW = $clog2(NUM_REQ);
   localparam int TW  = $clog2(STOP_BITS * DIV);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [TW-1:0]  BIT_TICKS  = TW'(DIV - 1);
   localparam logic [TW-1:0]  STOP_TICKS = TW'(STOP_BITS * DIV - 1);
   localparam logic [BW-1:0]  LAST_BIT   = BW'(DATA_BITS - 1);
   localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                 state;
   logic                   tx_q;
   logic                   lock;
   logic [IDW-1:0]         locked_id;
   logic [IDW-1:0]         rr_ptr;
   logic [IDW-1:0]         grant_q;
   logic [DATA_BITS-1:0]   shifter;
   logic [TW-1:0]          timer;
   logic [BW-1:0]          bit_idx;

   logic [IDW-1:0]         sel;
   logic [IDW-1:0]         cand;
   logic                   sel_ok;
   logic [DATA_BITS-1:0]   data_sel;
   logic                   last_sel;
   logic [NUM_REQ-1:0]     ready;

   // While a message is locked only its owner is eligible; otherwise search
   // upward from rr_ptr with wrap, first valid requester wins.
   always_comb begin
      sel    = rr_ptr;
      sel_ok = 1'b0;
      cand   = rr_ptr;
      if (lock) begin
         sel    = locked_id;
         sel_ok = bus.req_valid[locked_id];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_ok && bus.req_valid[cand]) begin
               sel    = cand;
               sel_ok = 1'b1;
            end
            cand = (cand == LAST_ID) ? '0 : cand + IDW'(1);
         end
      end

      data_sel = '0;
      last_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == sel) begin
            data_sel = bus.req_data[i*DATA_BITS +: DATA_BITS];
            last_sel = bus.req_last[i];
         end
      end

      ready = '0;
      if (state == IDLE && !reset && sel_ok) begin
         ready[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx_q      <= 1'b1;
         lock      <= 1'b0;
         locked_id <= '0;
         rr_ptr    <= '0;
         grant_q   <= '0;
         shifter   <= '0;
         timer     <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_ok) begin
                  shifter <= data_sel;
                  grant_q <= sel;
                  state   <= START;
                  tx_q    <= 1'b0;
                  timer   <= BIT_TICKS;
                  bit_idx <= '0;
                  if (last_sel) begin
                     lock   <= 1'b0;
                     rr_ptr <= (sel == LAST_ID) ? '0 : sel + IDW'(1);
                  end else begin
                     lock      <= 1'b1;
                     locked_id <= sel;
                  end
               end
            end
            START: begin
               if (timer == '0) begin
                  state <= DATA;
                  tx_q  <= shifter[0];
                  timer <= BIT_TICKS;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            DATA: begin
               if (timer == '0) begin
                  if (bit_idx == LAST_BIT) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                     timer <= STOP_TICKS;
                  end else begin
                     // Next bit goes out from shifter[1] as the shift happens.
                     shifter <= shifter >> 1;
                     tx_q    <= shifter[1];
                     bit_idx <= bit_idx + BW'(1);
                     timer   <= BIT_TICKS;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            STOP: begin
               if (timer == '0) begin
                  state <= IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.tx_data   = tx_q;
   assign bus.busy      = (state != IDLE) | lock;
   assign bus.grant_id  = grant_q;
   assign bus.state_dbg = state;

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one async serial transmit line between NUM_REQ on-chip requesters (console, debug monitor, trace, etc.).
- Arbitrates round-robin with message locking, so a multi-byte message from one requester is never interleaved with another's.
- Frames each accepted byte as start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits on tx_data.
- Sits between the requesting blocks and the board UART pin. The testbench serial decoder consumes its output in simulation.

Parameters:
- CLOCK_HZ, 27000000, system clock frequency.
- BIT_RATE_HZ, 115200, serial bit rate.
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- NUM_REQ, 4, number of requesters (2..8).
- Derived: DIV = CLOCK_HZ / BIT_RATE_HZ, integer truncation, required >= 2.
- Derived: IDW = clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte to send.
- req_data  in  NUM_REQ*DATA_BITS  byte for requester i in bits [i*DATA_BITS +: DATA_BITS].
- req_last  in  NUM_REQ  byte for requester i is the last byte of its message.
- req_ready  out  NUM_REQ  byte accepted from requester i this cycle (one-hot or zero).
- tx_data  out  1  serial line, idle high.
- busy  out  1  frame in progress or message lock held.
- grant_id  out  IDW  requester owning the current or most recent frame.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset values: tx_data=1, busy=0, grant_id=0, req_ready=0, lock=0, rr_ptr=0, state=IDLE.
- req_ready is forced to 0 during any cycle in which reset is high.
- States are IDLE, START, DATA, STOP.
- Transfer rule: a byte transfers on a rising edge where req_valid[i] & req_ready[i].
- req_ready is combinational and non-zero only in IDLE.
- Selection in IDLE, lock=0: the first i with req_valid[i], searching from rr_ptr upward with wrap modulo NUM_REQ. req_ready[i]=1 for that i only.
- Selection in IDLE, lock=1: only locked_id is eligible. req_ready[locked_id]=req_valid[locked_id]. All other requesters are ignored, even if the locked requester stalls indefinitely.
- On transfer:
  - Latch the data into the shifter; grant_id <= i; state <= START; bit timer <= DIV-1.
  - If req_last[i]=0: lock <= 1, locked_id <= i.
  - If req_last[i]=1: lock <= 0, rr_ptr <= (i+1) mod NUM_REQ.
- Bit timing: each bit level is held on tx_data for exactly DIV cycles. tx_data is registered.
  - The start bit (0) appears the cycle after the transfer.
- START: drive 0 for DIV cycles, then go to DATA.
- DATA: drive shifter[0] for DIV cycles, shift right, repeat DATA_BITS times, then go to STOP.
- STOP: drive 1 for STOP_BITS*DIV cycles, then go to IDLE.
- Frame spacing:
  - The earliest next transfer is in the first IDLE cycle.
  - Back-to-back frames therefore have exactly (1+DATA_BITS+STOP_BITS)*DIV + 1 cycles between start-bit falling edges.
  - tx_data stays high in IDLE.
- busy = (state != IDLE) | lock.
- grant_id holds its value in IDLE.
- Simultaneous requests: only one grant per IDLE cycle. Requesters not granted keep valid asserted and must hold their data stable until ready.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- rr_ptr is not updated on non-last bytes.
- Reset mid-frame:
  - The frame is aborted and tx_data=1 the next cycle.
  - The lock is cleared and no req_ready is issued for the aborted byte.
  - The partially sent byte is lost.
- req_valid deasserting without a transfer is legal and has no effect.

Test Plan:
- Single byte, framing: CLOCK_HZ=8, BIT_RATE_HZ=2 (DIV=4). req0 sends 0x55 with last=1.
  - Expect tx_data low for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4.
  - Expect req_ready[0] high for exactly 1 cycle and busy=0 after the stop bit.
- Round-robin: all 4 requesters continuously valid with last=1 and distinct bytes 0x10..0x13.
  - Expect grant order 0,1,2,3,0.
  - The bench decoder prints bytes 0x10,0x11,0x12,0x13,0x10.
- Message lock: req2 sends 0x41,0x42,0x43 (last on 0x43); req0 is valid with last=1 throughout.
  - Expect 0x41,0x42,0x43 contiguous, then req0.
  - Expect rr_ptr=3, so req3 is granted first if valid.
- Locked stall: req1 sends 0x20 (last=0), then drops valid for 100 cycles while req3 is valid.
  - Expect tx_data=1, busy=1 and req_ready=0 throughout.
  - When req1 resumes with 0x21 (last=1), it is sent before req3.
- Reset mid-frame: assert reset during the third data bit of 0x7E.
  - Expect tx_data=1 the next cycle, busy=0, grant_id=0 and no stop bit.
  - Expect the next request from req0 to be framed correctly.
- Back-to-back timing: req0 sends two bytes with last=1 and no other requesters.
  - Expect start-bit falling edges exactly 10*DIV+1 cycles apart (DATA_BITS=8, STOP_BITS=1).
